// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state type and channel constants for the load/store bus bridge
package bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CH_DM        = 0;
  localparam int CH_TIMER     = 1;
  localparam int CH_UART      = 2;
  localparam int BUS_ERR_DATA = 0;

endpackage

// File: rtl/periph_addr_decode.sv
// rtl/periph_addr_decode.sv - combinational byte address to slave channel decode
module periph_addr_decode #(
  parameter int AW         = 32,
  parameter int N_SLV      = 4,
  parameter int PERIPH_BIT = 30,
  parameter int SEL_LO     = 5,
  parameter int SEL_W      = 2,
  parameter int IW         = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] idx,
  output logic          valid
);
  import bus_pkg::*;

  logic [SEL_W:0] per_idx;
  logic           unused_addr;

  assign unused_addr = ^addr;

  // One extra bit so a full select field plus one cannot wrap back into range
  always_comb begin
    per_idx = {1'b0, addr[SEL_LO +: SEL_W]} + (SEL_W+1)'(1);
    if (addr[PERIPH_BIT]) begin
      idx   = IW'(per_idx);
      valid = (32'(per_idx) < 32'(N_SLV));
    end else begin
      idx   = IW'(CH_DM);
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/periph_bus_bridge.sv
// rtl/periph_bus_bridge.sv - multi-cycle CPU data port to N-slave bridge with wait states and timeout
module periph_bus_bridge #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int N_SLV      = 4,
  parameter int PERIPH_BIT = 30,
  parameter int SEL_LO     = 5,
  parameter int SEL_W      = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic                cpu_ready,
  output logic [DW-1:0]       cpu_rdata,
  output logic                cpu_err,
  output logic [N_SLV-1:0]    slv_sel,
  output logic                slv_rd,
  output logic                slv_wr,
  output logic [AW-1:0]       slv_addr,
  output logic [DW-1:0]       slv_wdata,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  input  logic [N_SLV-1:0]    slv_ack
);
  import bus_pkg::*;

  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] dec_idx;
  logic          dec_valid;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;

  periph_addr_decode #(
    .AW(AW), .N_SLV(N_SLV), .PERIPH_BIT(PERIPH_BIT), .SEL_LO(SEL_LO), .SEL_W(SEL_W), .IW(IW)
  ) u_decode (
    .addr (cpu_addr),
    .idx  (dec_idx),
    .valid(dec_valid)
  );

  // slv_sel is one-hot during ACCESS and zero elsewhere, so it masks out stray acks
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      sel_ack   = sel_ack | (slv_ack[k] & slv_sel[k]);
      sel_rdata = sel_rdata | (slv_rdata[k*DW +: DW] & {DW{slv_sel[k]}});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      slv_sel   <= '0;
      slv_rd    <= 1'b0;
      slv_wr    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          if (cpu_req) begin
            slv_addr  <= cpu_addr;
            slv_wdata <= cpu_wdata;
            if (dec_valid) begin
              slv_sel <= N_SLV'(1) << dec_idx;
              slv_rd  <= ~cpu_wr;
              slv_wr  <= cpu_wr;
              state   <= ACCESS;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= DW'(BUS_ERR_DATA);
              state     <= DONE;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          // Ack wins over a timeout landing in the same cycle
          if (sel_ack || cnt == CW'(TIMEOUT)) begin
            cpu_ready <= 1'b1;
            cpu_err   <= ~sel_ack;
            cpu_rdata <= (sel_ack && slv_rd) ? sel_rdata : DW'(BUS_ERR_DATA);
            slv_sel   <= '0;
            slv_rd    <= 1'b0;
            slv_wr    <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// tb/tb_periph_bus_bridge.sv - directed vector bench for periph_bus_bridge
module tb_periph_bus_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_wr;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_ready, cpu_err;
  logic [31:0]  cpu_rdata;
  logic [3:0]   slv_sel;
  logic         slv_rd, slv_wr;
  logic [31:0]  slv_addr, slv_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  periph_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .slv_sel(slv_sel),
    .slv_rd(slv_rd), .slv_wr(slv_wr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ack(slv_ack)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    int          ch;
    logic [31:0] data;
    logic [3:0]  spur;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_sel;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          cyc, acc, lat;
    logic        strobe_ok;
    logic [31:0] hold;
    slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    slv_rdata[v.ch*32 +: 32] = v.data;
    cpu_req = 1'b1; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    slv_ack = 4'b1111;
    cyc = 0; acc = 0; lat = -1; strobe_ok = 1'b1;
    while (lat < 0 && cyc < 40) begin
      tick();
      cyc++;
      slv_ack = 4'b0000;
      if (cpu_ready) begin
        lat = cyc;
        slv_ack = 4'b1111;
      end else if (slv_sel != 4'b0000) begin
        acc++;
        if (slv_sel !== v.exp_sel || slv_rd !== ~v.wr || slv_wr !== v.wr ||
            slv_addr !== v.addr || slv_wdata !== v.wdata) strobe_ok = 1'b0;
        slv_ack = v.spur;
        if (v.wait_n >= 0 && acc == v.wait_n + 1) slv_ack = slv_ack | v.exp_sel;
      end else if (slv_rd || slv_wr) begin
        strobe_ok = 1'b0;
      end
    end
    check($sformatf("v%0d latency", id), lat, v.lat);
    check($sformatf("v%0d rdata", id), cpu_rdata, v.exp_rdata);
    check($sformatf("v%0d err", id), {31'b0, cpu_err}, {31'b0, v.exp_err});
    check($sformatf("v%0d access_cycles", id), acc, v.exp_acc);
    check($sformatf("v%0d strobes", id), {31'b0, strobe_ok}, 32'd1);
    hold = cpu_rdata;
    cpu_req = 1'b0;
    slv_ack = 4'b0000;
    tick();
    check($sformatf("v%0d ready_pulse", id), {30'b0, cpu_ready, cpu_err}, 32'd0);
    check($sformatf("v%0d rdata_hold", id), cpu_rdata, hold);
  endtask

  initial begin
    logic seen_ready;

    //          wr    addr          wdata         wait ch data          spur     lat exp_rdata     err   sel      acc
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        0,  0, 32'h1234_5678, 4'b0000, 2,  32'h1234_5678, 1'b0, 4'b0001, 1};
    vecs[1] = '{1'b1, 32'h4000_0008, 32'hA5A5_0001, 3, 1, 32'h7777_7777, 4'b0000, 5,  32'h0,         1'b0, 4'b0010, 4};
    vecs[2] = '{1'b0, 32'h4000_0020, 32'h0,       -1,  2, 32'h9999_9999, 4'b1000, 17, 32'h0,         1'b1, 4'b0100, 16};
    vecs[3] = '{1'b0, 32'h4000_0060, 32'h0,        0,  3, 32'h8888_8888, 4'b0000, 1,  32'h0,         1'b1, 4'b0000, 0};
    vecs[4] = '{1'b0, 32'h4000_0004, 32'h0,       15,  1, 32'hCAFE_F00D, 4'b0000, 17, 32'hCAFE_F00D, 1'b0, 4'b0010, 16};
    vecs[5] = '{1'b0, 32'h4000_0040, 32'h0,        1,  3, 32'h0BAD_BEEF, 4'b0001, 3,  32'h0BAD_BEEF, 1'b0, 4'b1000, 2};
    vecs[6] = '{1'b1, 32'h0000_0060, 32'hDEAD_BEEF, 0, 0, 32'h5A5A_5A5A, 4'b0000, 2,  32'h0,         1'b0, 4'b0001, 1};

    reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    slv_rdata = '0; slv_ack = '0;
    #1;
    check("reset outputs", {cpu_ready, cpu_err, slv_rd, slv_wr, slv_sel}, 32'd0);
    check("reset data", cpu_rdata | slv_addr | slv_wdata, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Back-to-back: request held through DONE into IDLE
    slv_rdata = {32'h0, 32'h0, 32'h5555_AAAA, 32'hAAAA_5555};
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0010; slv_ack = 4'b0000;
    tick();
    check("b2b first sel", {28'b0, slv_sel}, 32'h1);
    slv_ack = 4'b0001;
    tick();
    check("b2b first ready", {31'b0, cpu_ready}, 32'd1);
    check("b2b first rdata", cpu_rdata, 32'hAAAA_5555);
    cpu_addr = 32'h4000_0008; slv_ack = 4'b0000;
    tick();
    check("b2b idle gap", {27'b0, cpu_ready, slv_sel}, 32'd0);
    tick();
    check("b2b second sel", {28'b0, slv_sel}, 32'h2);
    check("b2b second addr", slv_addr, 32'h4000_0008);
    slv_ack = 4'b0010;
    tick();
    check("b2b second ready", {31'b0, cpu_ready}, 32'd1);
    check("b2b second rdata", cpu_rdata, 32'h5555_AAAA);
    cpu_req = 1'b0; slv_ack = 4'b0000;
    tick();

    // Asynchronous reset in the middle of an access
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h4000_0020;
    tick(); tick();
    check("pre-reset rd", {31'b0, slv_rd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset strobes", {27'b0, slv_rd, slv_sel}, 32'd0);
    cpu_req = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_ready) seen_ready = 1'b1;
    end
    reset = 1'b0;
    tick();
    if (cpu_ready) seen_ready = 1'b1;
    check("no ready on reset", {31'b0, seen_ready}, 32'd0);
    run_vec(10, vecs[0]);
    run_vec(12, vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/periph_bus_bridge.md
Name: periph_bus_bridge

Overview:
- Multi-cycle memory-mapped load/store bridge between the CPU data port and N slave channels (data memory, timer, UART, and future peripherals).
- Replaces the old single-cycle combinational DM/peripheral split, which had fixed thresholds, with three features:
  - parametrised slave count and address decode;
  - a per-access req/ack handshake with wait states;
  - a timeout and bus-error path.
- Sits between the execute stage (ALU address, rt store data) and the slaves.
- Stalls the CPU until the access completes.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- N_SLV, 4: number of slave channels. Channel 0 is data memory; channels 1..N_SLV-1 are peripherals.
- PERIPH_BIT, 30: address bit that selects peripheral space (1) versus data memory (0).
- SEL_LO, 5: LSB of the peripheral select field.
- SEL_W, 2: width of the peripheral select field.
- TIMEOUT, 15: maximum number of ACCESS cycles allowed without an ack.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held high until cpu_ready.
- cpu_wr  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  store data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  load data; valid while cpu_ready is high.
- cpu_err  out  1  bus error; valid while cpu_ready is high.
- slv_sel  out  N_SLV  one-hot channel select.
- slv_rd  out  1  read strobe, qualified by slv_sel.
- slv_wr  out  1  write strobe, qualified by slv_sel.
- slv_addr  out  AW  latched address.
- slv_wdata  out  DW  latched store data.
- slv_rdata  in  N_SLV*DW  packed read data; channel k occupies bits [k*DW +: DW].
- slv_ack  in  N_SLV  per-channel completion.

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high.
- Reset state:
  - FSM is in IDLE.
  - cpu_ready=0, cpu_err=0, cpu_rdata=0.
  - slv_sel=0, slv_rd=0, slv_wr=0, slv_addr=0, slv_wdata=0.
  - Timeout counter=0.
- Decode:
  - addr[PERIPH_BIT]==0 → idx=0.
  - Otherwise idx = 1 + addr[SEL_LO +: SEL_W].
  - The access is invalid if idx ≥ N_SLV.
- IDLE:
  - If cpu_req=1: latch addr, wdata and wr, then decode.
  - Valid access → go to ACCESS. Next cycle: slv_sel[idx]=1, slv_rd=~wr, slv_wr=wr.
  - Invalid access → go to DONE with err=1 and no slave strobes.
- ACCESS:
  - Strobes and latched address/data stay constant for the whole state.
  - Counter increments every cycle.
  - If slv_ack[idx]=1: capture slv_rdata[idx] for loads, or 0 for stores; err=0; go to DONE.
  - Else if counter==TIMEOUT: err=1, rdata=0, go to DONE.
  - Ack has priority over timeout when both occur in the same cycle.
- DONE:
  - Strobes and slv_sel are cleared.
  - cpu_ready=1 for exactly one cycle, with cpu_rdata and cpu_err valid.
  - Then go to IDLE, with the counter cleared.
- Outside DONE: cpu_ready=0. cpu_rdata holds its last value; cpu_err returns to 0.
- Latency:
  - Zero-wait slave (ack in the first ACCESS cycle): req at cycle 0 → cpu_ready at cycle 2.
  - Each extra wait cycle adds 1.
  - Invalid address: cpu_ready at cycle 1.
- Ack handling:
  - Acks on unselected channels are ignored.
  - Acks arriving in IDLE or DONE are ignored.
- Back-to-back: cpu_req still high in the cycle after DONE (i.e. in IDLE) starts a new access. No bubble is required beyond the IDLE cycle.
- Reset during ACCESS: strobes drop immediately (asynchronous), no cpu_ready is issued, FSM returns to IDLE.
- Stores to channel 0 use the same handshake. The data-memory wrapper asserts ack on the write cycle.

Decomposition:
- Shared package (bus_pkg) contains:
  - state enum {IDLE, ACCESS, DONE};
  - channel index constants CH_DM=0, CH_TIMER=1, CH_UART=2;
  - BUS_ERR_DATA=0.
- Sub-module periph_addr_decode:
  - purely combinational: addr → idx, valid;
  - parametrised by N_SLV, PERIPH_BIT, SEL_LO, SEL_W;
  - reused by the instruction-side bridge.

Test Plan:
- Load from DM, addr 0x0000_0010, slave 0 acks in its first ACCESS cycle with 0x1234_5678 → cpu_ready at cycle 2, cpu_rdata=0x1234_5678, cpu_err=0, slv_sel=4'b0001 during ACCESS only.
- Store to timer, addr 0x4000_0008 (idx 1), wdata 0xA5A5_0001, ack after 3 wait cycles → slv_wr=1 with slv_sel=4'b0010 for 4 cycles, slv_wdata=0xA5A5_0001, cpu_ready at cycle 5, cpu_rdata=0.
- Load from UART, addr 0x4000_0020 (idx 2), slave never acks → cpu_ready at cycle 1+TIMEOUT+1=17, cpu_err=1, cpu_rdata=0; slave 3 acking during the access is ignored.
- Load at addr 0x4000_0060 (idx 4 ≥ N_SLV) → cpu_ready at cycle 1, cpu_err=1, no slave strobe in any cycle.
- Load to channel 1 with ack and timeout coinciding at counter=15 → err=0, data captured. Back-to-back request held high → second access's strobes begin 2 cycles after the first cpu_ready.
- reset asserted asynchronously mid-ACCESS → slv_rd and slv_sel go to 0 before the next clk edge, no cpu_ready pulse; after release, a fresh load completes normally.
